// File: rtl/alu_pkg.sv
// Shared types and default opcodes for the UART-driven ALU command controller.
package alu_pkg;

    typedef enum logic [3:0] {
        ADD  = 4'd0,
        SUB  = 4'd1,
        MUL  = 4'd2,
        DIV  = 4'd3,
        AND  = 4'd4,
        OR   = 4'd5,
        NAND = 4'd6,
        NOR  = 4'd7,
        XOR  = 4'd8,
        XNOR = 4'd9,
        EQ   = 4'd10,
        GT   = 4'd11,
        LT   = 4'd12,
        SHR  = 4'd13,
        SHL  = 4'd14
    } alu_op_e;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_GET_A    = 3'd1,
        ST_GET_B    = 3'd2,
        ST_GET_FUN  = 3'd3,
        ST_EXEC     = 3'd4,
        ST_WAIT_RES = 3'd5,
        ST_SEND_LO  = 3'd6,
        ST_SEND_HI  = 3'd7
    } ctrl_state_e;

    localparam logic [7:0] CMD_ALU_OPER_DEF  = 8'hCC;
    localparam logic [7:0] CMD_ALU_NOPER_DEF = 8'hDD;

endpackage

// File: rtl/alu_cmd_ctrl.sv
// Decodes RX command frames into ALU operations and returns the 2-byte result over TX.
module alu_cmd_ctrl
    import alu_pkg::*;
#(
    parameter int                    DATA_WIDTH    = 8,
    parameter logic [DATA_WIDTH-1:0] CMD_ALU_OPER  = DATA_WIDTH'(CMD_ALU_OPER_DEF),
    parameter logic [DATA_WIDTH-1:0] CMD_ALU_NOPER = DATA_WIDTH'(CMD_ALU_NOPER_DEF),
    parameter int                    RES_TIMEOUT   = 4
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic [DATA_WIDTH-1:0]     RX_P_DATA,
    input  logic                      RX_D_VLD,
    input  logic [2*DATA_WIDTH-1:0]   ALU_OUT,
    input  logic                      OUT_VALID,
    output logic                      ALU_EN,
    output alu_op_e                   ALU_FUN,
    output logic [DATA_WIDTH-1:0]     OPER_A,
    output logic [DATA_WIDTH-1:0]     OPER_B,
    output logic [DATA_WIDTH-1:0]     TX_P_DATA,
    output logic                      TX_D_VLD,
    input  logic                      TX_READY,
    output logic                      ERR_CMD,
    output logic                      ERR_OVR,
    output logic                      ERR_TMO
);

    localparam int RES_W = 2 * DATA_WIDTH;
    localparam int TMO_W = (RES_TIMEOUT > 1) ? $clog2(RES_TIMEOUT) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(RES_TIMEOUT - 1);

    ctrl_state_e           state_q, state_d;
    logic [DATA_WIDTH-1:0] oper_a_q, oper_a_d;
    logic [DATA_WIDTH-1:0] oper_b_q, oper_b_d;
    alu_op_e               alu_fun_q, alu_fun_d;
    logic [RES_W-1:0]      result_q, result_d;
    logic [DATA_WIDTH-1:0] tx_data_q, tx_data_d;
    logic                  tx_vld_q, tx_vld_d;
    logic                  alu_en_q, alu_en_d;
    logic                  err_cmd_q, err_cmd_d;
    logic                  err_ovr_q, err_ovr_d;
    logic                  err_tmo_q, err_tmo_d;
    logic [TMO_W-1:0]      tmo_cnt_q, tmo_cnt_d;
    logic                  tx_hs;

    assign tx_hs = tx_vld_q & TX_READY;

    always_comb begin
        state_d   = state_q;
        oper_a_d  = oper_a_q;
        oper_b_d  = oper_b_q;
        alu_fun_d = alu_fun_q;
        result_d  = result_q;
        tx_data_d = tx_data_q;
        tx_vld_d  = tx_vld_q;
        tmo_cnt_d = tmo_cnt_q;
        alu_en_d  = 1'b0;
        err_cmd_d = 1'b0;
        err_ovr_d = 1'b0;
        err_tmo_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (RX_D_VLD) begin
                    if (RX_P_DATA == CMD_ALU_OPER) begin
                        state_d = ST_GET_A;
                    end else if (RX_P_DATA == CMD_ALU_NOPER) begin
                        state_d = ST_GET_FUN;
                    end else begin
                        err_cmd_d = 1'b1;
                    end
                end
            end
            ST_GET_A: begin
                if (RX_D_VLD) begin
                    oper_a_d = RX_P_DATA;
                    state_d  = ST_GET_B;
                end
            end
            ST_GET_B: begin
                if (RX_D_VLD) begin
                    oper_b_d = RX_P_DATA;
                    state_d  = ST_GET_FUN;
                end
            end
            ST_GET_FUN: begin
                // ALU_EN is registered, so raising it here makes it coincide with EXEC.
                if (RX_D_VLD) begin
                    alu_fun_d = alu_op_e'(RX_P_DATA[3:0]);
                    alu_en_d  = 1'b1;
                    state_d   = ST_EXEC;
                end
            end
            ST_EXEC: begin
                tmo_cnt_d = '0;
                err_ovr_d = RX_D_VLD;
                state_d   = ST_WAIT_RES;
            end
            ST_WAIT_RES: begin
                err_ovr_d = RX_D_VLD;
                if (OUT_VALID) begin
                    result_d  = ALU_OUT;
                    tx_data_d = ALU_OUT[DATA_WIDTH-1:0];
                    tx_vld_d  = 1'b1;
                    state_d   = ST_SEND_LO;
                end else if (tmo_cnt_q == TMO_LAST) begin
                    err_tmo_d = 1'b1;
                    state_d   = ST_IDLE;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 1'b1;
                end
            end
            ST_SEND_LO: begin
                err_ovr_d = RX_D_VLD;
                if (tx_hs) begin
                    tx_data_d = result_q[RES_W-1:DATA_WIDTH];
                    state_d   = ST_SEND_HI;
                end
            end
            ST_SEND_HI: begin
                err_ovr_d = RX_D_VLD;
                if (tx_hs) begin
                    tx_vld_d = 1'b0;
                    state_d  = ST_IDLE;
                end
            end
            default: begin
                tx_vld_d = 1'b0;
                state_d  = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q   <= ST_IDLE;
            oper_a_q  <= '0;
            oper_b_q  <= '0;
            alu_fun_q <= ADD;
            result_q  <= '0;
            tx_data_q <= '0;
            tx_vld_q  <= 1'b0;
            tmo_cnt_q <= '0;
            alu_en_q  <= 1'b0;
            err_cmd_q <= 1'b0;
            err_ovr_q <= 1'b0;
            err_tmo_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            oper_a_q  <= oper_a_d;
            oper_b_q  <= oper_b_d;
            alu_fun_q <= alu_fun_d;
            result_q  <= result_d;
            tx_data_q <= tx_data_d;
            tx_vld_q  <= tx_vld_d;
            tmo_cnt_q <= tmo_cnt_d;
            alu_en_q  <= alu_en_d;
            err_cmd_q <= err_cmd_d;
            err_ovr_q <= err_ovr_d;
            err_tmo_q <= err_tmo_d;
        end
    end

    assign ALU_EN    = alu_en_q;
    assign ALU_FUN   = alu_fun_q;
    assign OPER_A    = oper_a_q;
    assign OPER_B    = oper_b_q;
    assign TX_P_DATA = tx_data_q;
    assign TX_D_VLD  = tx_vld_q;
    assign ERR_CMD   = err_cmd_q;
    assign ERR_OVR   = err_ovr_q;
    assign ERR_TMO   = err_tmo_q;

endmodule

// File: tb/tb_alu_cmd_ctrl.sv
// Directed bench for alu_cmd_ctrl with a small registered ALU stand-in and TX byte monitor.
module tb_alu_cmd_ctrl;
    import alu_pkg::*;

    logic        CLK = 1'b0;
    logic        RST;
    logic [7:0]  RX_P_DATA;
    logic        RX_D_VLD;
    logic [15:0] ALU_OUT;
    logic        OUT_VALID;
    logic        ALU_EN;
    alu_op_e     ALU_FUN;
    logic [7:0]  OPER_A, OPER_B, TX_P_DATA;
    logic        TX_D_VLD, TX_READY;
    logic        ERR_CMD, ERR_OVR, ERR_TMO;

    int checks = 0;
    int errors = 0;

    alu_cmd_ctrl dut (
        .CLK(CLK), .RST(RST),
        .RX_P_DATA(RX_P_DATA), .RX_D_VLD(RX_D_VLD),
        .ALU_OUT(ALU_OUT), .OUT_VALID(OUT_VALID),
        .ALU_EN(ALU_EN), .ALU_FUN(ALU_FUN),
        .OPER_A(OPER_A), .OPER_B(OPER_B),
        .TX_P_DATA(TX_P_DATA), .TX_D_VLD(TX_D_VLD), .TX_READY(TX_READY),
        .ERR_CMD(ERR_CMD), .ERR_OVR(ERR_OVR), .ERR_TMO(ERR_TMO)
    );

    always #5 CLK = ~CLK;

    // Registered ALU stand-in: result and OUT_VALID one cycle after ALU_EN.
    logic        alu_live = 1'b1;
    logic        alu_vld;
    logic [15:0] alu_res;

    function automatic logic [15:0] alu_model(input logic [7:0] a, input logic [7:0] b,
                                              input logic [3:0] f);
        logic [15:0] a16, b16;
        a16 = {8'h00, a};
        b16 = {8'h00, b};
        case (f)
            4'd0:    return a16 + b16;
            4'd1:    return a16 - b16;
            4'd2:    return a16 * b16;
            default: return 16'h0000;
        endcase
    endfunction

    always @(posedge CLK or negedge RST) begin
        if (!RST) begin
            alu_vld <= 1'b0;
            alu_res <= 16'h0000;
        end else begin
            alu_vld <= ALU_EN & alu_live;
            if (ALU_EN) alu_res <= alu_model(OPER_A, OPER_B, ALU_FUN);
        end
    end

    assign ALU_OUT   = alu_res;
    assign OUT_VALID = alu_vld;

    // Monitor: log every TX handshake and count strobes.
    logic [7:0] tx_log [0:63];
    int tx_n = 0, en_n = 0, cmd_n = 0, ovr_n = 0, tmo_n = 0;

    always @(posedge CLK) begin
        if (TX_D_VLD && TX_READY) begin
            tx_log[tx_n[5:0]] <= TX_P_DATA;
            tx_n <= tx_n + 1;
        end
        if (ALU_EN)  en_n  <= en_n + 1;
        if (ERR_CMD) cmd_n <= cmd_n + 1;
        if (ERR_OVR) ovr_n <= ovr_n + 1;
        if (ERR_TMO) tmo_n <= tmo_n + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        RX_P_DATA = b;
        RX_D_VLD  = 1'b1;
        cyc();
        RX_D_VLD  = 1'b0;
    endtask

    task automatic wait_tx(input int target);
        int k;
        k = 0;
        while (tx_n < target && k < 40) begin
            cyc();
            k++;
        end
        check("tx_done", 32'(tx_n >= target), 32'd1);
    endtask

    int base, e0, c0, o0, t0;
    logic stable;

    initial begin
        RST = 1'b0; RX_P_DATA = 8'h00; RX_D_VLD = 1'b0; TX_READY = 1'b1;
        #1;
        cyc(); cyc(); cyc();
        check("rst_alu_en", ALU_EN, 0);
        check("rst_tx_vld", TX_D_VLD, 0);
        check("rst_oper_a", OPER_A, 0);
        check("rst_oper_b", OPER_B, 0);
        check("rst_fun",    ALU_FUN, 0);
        check("rst_tx_data", TX_P_DATA, 0);
        check("rst_errs",   {ERR_CMD, ERR_OVR, ERR_TMO}, 0);
        RST = 1'b1;
        cyc();

        // CC 05 03 00 -> ADD, bytes 08 00, first TX byte two cycles after EXEC
        base = tx_n; e0 = en_n;
        send_byte(8'hCC); send_byte(8'h05); send_byte(8'h03); send_byte(8'h00);
        check("t1_alu_en", ALU_EN, 1);
        check("t1_oper_a", OPER_A, 8'h05);
        check("t1_oper_b", OPER_B, 8'h03);
        check("t1_fun",    ALU_FUN, ADD);
        cyc();
        check("t1_alu_en_off", ALU_EN, 0);
        check("t1_tx_vld_wait", TX_D_VLD, 0);
        cyc();
        check("t1_tx_vld_lat", TX_D_VLD, 1);
        check("t1_tx_lo_lat", TX_P_DATA, 8'h08);
        wait_tx(base + 2);
        check("t1_lo", tx_log[base[5:0]], 8'h08);
        check("t1_hi", tx_log[6'(base + 1)], 8'h00);
        check("t1_en_cnt", en_n - e0, 1);
        cyc();
        check("t1_tx_vld_idle", TX_D_VLD, 0);

        // DD 02 -> MUL on stored 05,03 = 000F
        base = tx_n;
        send_byte(8'hDD); send_byte(8'h02);
        check("t2_fun", ALU_FUN, MUL);
        wait_tx(base + 2);
        check("t2_lo", tx_log[base[5:0]], 8'h0F);
        check("t2_hi", tx_log[6'(base + 1)], 8'h00);

        // CC FF FF 02 with transmitter stalled: FF*FF = FE01
        base = tx_n; TX_READY = 1'b0;
        send_byte(8'hCC); send_byte(8'hFF); send_byte(8'hFF); send_byte(8'h02);
        cyc(); cyc();
        stable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (TX_D_VLD !== 1'b1 || TX_P_DATA !== 8'h01) stable = 1'b0;
            cyc();
        end
        check("t3_hold_stable", stable, 1);
        check("t3_hold_no_tx", tx_n - base, 0);
        TX_READY = 1'b1;
        wait_tx(base + 2);
        check("t3_lo", tx_log[base[5:0]], 8'h01);
        check("t3_hi", tx_log[6'(base + 1)], 8'hFE);

        // Unknown opcode 12 then a normal frame
        e0 = en_n; c0 = cmd_n;
        send_byte(8'h12);
        check("t4_err_cmd", ERR_CMD, 1);
        cyc();
        check("t4_err_cmd_pulse", ERR_CMD, 0);
        check("t4_no_alu_en", en_n - e0, 0);
        base = tx_n;
        send_byte(8'hCC); send_byte(8'h01); send_byte(8'h02); send_byte(8'h00);
        wait_tx(base + 2);
        check("t4_lo", tx_log[base[5:0]], 8'h03);
        check("t4_hi", tx_log[6'(base + 1)], 8'h00);
        check("t4_cmd_cnt", cmd_n - c0, 1);

        // Upper FUN bits ignored: F1 -> SUB on 01,02 = FFFF; code 15 passes through
        base = tx_n;
        send_byte(8'hDD); send_byte(8'hF1);
        check("t5_fun_sub", ALU_FUN, SUB);
        wait_tx(base + 2);
        check("t5_lo", tx_log[base[5:0]], 8'hFF);
        check("t5_hi", tx_log[6'(base + 1)], 8'hFF);
        base = tx_n;
        send_byte(8'hDD); send_byte(8'h0F);
        check("t5_fun_15", ALU_FUN, 4'hF);
        wait_tx(base + 2);

        // RX byte during SEND_HI -> ERR_OVR, bytes unaffected
        base = tx_n; o0 = ovr_n; TX_READY = 1'b0;
        send_byte(8'hCC); send_byte(8'h05); send_byte(8'h03); send_byte(8'h00);
        cyc(); cyc();
        TX_READY = 1'b1;
        cyc();
        TX_READY = 1'b0;
        send_byte(8'h77);
        check("t6_err_ovr", ERR_OVR, 1);
        check("t6_hi_vld", TX_D_VLD, 1);
        check("t6_hi_data", TX_P_DATA, 8'h00);
        check("t6_one_sent", tx_n - base, 1);
        TX_READY = 1'b1;
        wait_tx(base + 2);
        check("t6_lo", tx_log[base[5:0]], 8'h08);
        check("t6_hi", tx_log[6'(base + 1)], 8'h00);
        check("t6_ovr_cnt", ovr_n - o0, 1);

        // OUT_VALID withheld -> ERR_TMO after four WAIT_RES cycles
        alu_live = 1'b0; base = tx_n; t0 = tmo_n;
        send_byte(8'hCC); send_byte(8'h01); send_byte(8'h01); send_byte(8'h00);
        cyc(); cyc(); cyc(); cyc();
        check("t7_no_tmo_yet", ERR_TMO, 0);
        cyc();
        check("t7_err_tmo", ERR_TMO, 1);
        check("t7_tx_vld", TX_D_VLD, 0);
        cyc();
        check("t7_tmo_pulse", tmo_n - t0, 1);
        check("t7_no_tx", tx_n - base, 0);
        alu_live = 1'b1;

        // Reset mid-frame, then DD 00 on cleared operands
        send_byte(8'hCC); send_byte(8'h05);
        check("t8_a_loaded", OPER_A, 8'h05);
        #2 RST = 1'b0;
        #1;
        check("t8_rst_a", OPER_A, 0);
        check("t8_rst_b", OPER_B, 0);
        check("t8_rst_fun", ALU_FUN, 0);
        check("t8_rst_tx", {TX_D_VLD, ALU_EN, ERR_CMD, ERR_OVR, ERR_TMO}, 0);
        cyc(); cyc();
        RST = 1'b1;
        cyc();
        base = tx_n; e0 = en_n;
        send_byte(8'hDD); send_byte(8'h00);
        wait_tx(base + 2);
        check("t8_lo", tx_log[base[5:0]], 8'h00);
        check("t8_hi", tx_log[6'(base + 1)], 8'h00);
        check("t8_en_cnt", en_n - e0, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
